// File: rtl/shift_mix_addkey_stage.sv
// Forward AES-128 round: ShiftRows -> MixColumns (bypassable) -> AddRoundKey.
// The datapath is split into two valid/ready stages; S2 holds only the key XOR.

module shift_mix_addkey_col (
  input  logic [0:31] col,
  input  logic        bypass,
  output logic [0:31] res
);
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;
  logic [0:31] mixed;

  assign a0 = col[0:7];
  assign a1 = col[8:15];
  assign a2 = col[16:23];
  assign a3 = col[24:31];
  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3a is folded in as xtime(a) ^ a.
  assign mixed[0:7]   = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign mixed[8:15]  = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign mixed[16:23] = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign mixed[24:31] = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

  assign res = bypass ? col : mixed;
endmodule

module shift_mix_addkey_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         In_valid,
  output logic         In_ready,
  input  logic [0:127] Data_in,
  input  logic [0:127] Round_key,
  input  logic         Last_round,
  output logic         Out_valid,
  input  logic         Out_ready,
  output logic [0:127] Data_out
);
  localparam int NUM_COLS = 4;

  typedef struct packed {
    logic [0:127] state;
    logic [0:127] key;
  } s1_t;

  logic [0:127] sr;
  logic [0:127] mc;
  s1_t          s1;
  logic [2:1]   vld_pipe;
  logic         adv1, adv2;

  // Byte k = 4c + r; row r of column c is taken from column (c + r) mod 4.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_sr
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[8*(4*c+r) +: 8] = Data_in[8*(4*((c+r)%4)+r) +: 8];
    end
  end

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    shift_mix_addkey_col u_col (
      .col    (sr[32*c +: 32]),
      .bypass (Last_round),
      .res    (mc[32*c +: 32])
    );
  end

  assign adv2      = !vld_pipe[2] || Out_ready;
  assign adv1      = !vld_pipe[1] || adv2;
  assign In_ready  = adv1;
  assign Out_valid = vld_pipe[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1       <= '0;
      Data_out <= '0;
    end else begin
      if (adv1) vld_pipe[1] <= In_valid;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
      if (adv1 && In_valid) begin
        s1.state <= mc;
        s1.key   <= Round_key;
      end
      if (adv2 && vld_pipe[1]) Data_out <= s1.state ^ s1.key;
    end
  end
endmodule

// File: tb/tb_shift_mix_addkey_stage.sv
// Bench for shift_mix_addkey_stage: known-answer vectors plus randomized
// streams scored against a byte-array AES round model.

module tb_shift_mix_addkey_stage;
  logic         clk = 1'b0;
  logic         rst;
  logic         In_valid, In_ready, Last_round, Out_valid, Out_ready;
  logic [0:127] Data_in, Round_key, Data_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];

  shift_mix_addkey_stage dut (
    .clk        (clk),
    .rst        (rst),
    .In_valid   (In_valid),
    .In_ready   (In_ready),
    .Data_in    (Data_in),
    .Round_key  (Round_key),
    .Last_round (Last_round),
    .Out_valid  (Out_valid),
    .Out_ready  (Out_ready),
    .Data_out   (Data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      m = m >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k, input bit lr);
    logic [7:0] b[16], s[16], o[16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = d[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      if (lr) begin
        for (int r = 0; r < 4; r++) o[4*c+r] = s[4*c+r];
      end else begin
        o[4*c+0] = gmul(s[4*c],2) ^ gmul(s[4*c+1],3) ^ s[4*c+2] ^ s[4*c+3];
        o[4*c+1] = s[4*c] ^ gmul(s[4*c+1],2) ^ gmul(s[4*c+2],3) ^ s[4*c+3];
        o[4*c+2] = s[4*c] ^ s[4*c+1] ^ gmul(s[4*c+2],2) ^ gmul(s[4*c+3],3);
        o[4*c+3] = gmul(s[4*c],3) ^ s[4*c+1] ^ s[4*c+2] ^ gmul(s[4*c+3],2);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i] ^ k[127-8*i -: 8];
    return res;
  endfunction

  task automatic rand_inputs();
    Data_in    = {$urandom, $urandom, $urandom, $urandom};
    Round_key  = {$urandom, $urandom, $urandom, $urandom};
    Last_round = ($urandom_range(0, 3) == 0);
  endtask

  task automatic dir_test(input string tag, input logic [127:0] d, input logic [127:0] k,
                          input bit lr, input logic [127:0] exp);
    @(negedge clk);
    In_valid = 1'b1; Data_in = d; Round_key = k; Last_round = lr; Out_ready = 1'b1;
    #1 chk({tag, "_in_ready"}, In_ready, 1);
    @(negedge clk);
    In_valid = 1'b0; rand_inputs();
    #1 chk({tag, "_early_valid"}, Out_valid, 0);
    @(negedge clk);
    #1 chk({tag, "_valid"}, Out_valid, 1);
    chk({tag, "_data"}, Data_out, exp);
  endtask

  // mode 0: random valid/ready, 1: full throughput, 2: back-pressure cycles 2..6
  task automatic run_stream(input int mode, input int nbeats);
    int sent = 0, got = 0, cyc = 0, occ = 0;
    int first_acc = -1, first_ov = -1, last_ov = -1;
    bit prev_stall = 1'b0, saw_ir_low = 1'b0;
    logic [127:0] prev_data = '0;
    logic [127:0] e;
    while (got < nbeats && cyc < 3000) begin
      @(negedge clk);
      rand_inputs();
      case (mode)
        1:       begin In_valid = (sent < nbeats); Out_ready = 1'b1; end
        2:       begin In_valid = (sent < nbeats); Out_ready = !(cyc >= 2 && cyc <= 6); end
        default: begin
          In_valid  = (sent < nbeats) && ($urandom_range(0, 3) != 0);
          Out_ready = ($urandom_range(0, 3) != 0);
        end
      endcase
      #1;
      if (prev_stall) begin
        chk("stall_valid", Out_valid, 1);
        chk("stall_data", Data_out, prev_data);
      end
      chk("in_ready", In_ready, (occ < 2) || Out_ready);
      if (!In_ready) saw_ir_low = 1'b1;
      if (Out_valid && Out_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("stream_data", Data_out, e);
        end
        got++; occ--;
        if (first_ov < 0) first_ov = cyc;
        last_ov = cyc;
      end
      if (In_valid && In_ready) begin
        exp_q.push_back(ref_round(Data_in, Round_key, Last_round));
        sent++; occ++;
        if (first_acc < 0) first_acc = cyc;
      end
      prev_stall = Out_valid && !Out_ready;
      prev_data  = Data_out;
      cyc++;
    end
    chk("beats_out", got, nbeats);
    chk("queue_empty", exp_q.size(), 0);
    if (mode == 1) begin
      chk("first_latency", first_ov - first_acc, 2);
      chk("consecutive", last_ov - first_ov, nbeats - 1);
    end
    if (mode == 2) chk("in_ready_dropped", saw_ir_low, 1);
    In_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, Out_valid, 0);
    chk({tag, "_data_out"}, Data_out, 0);
    chk({tag, "_in_ready"}, In_ready, 1);
  endtask

  initial begin
    rst = 1'b1; In_valid = 1'b0; Out_ready = 1'b1;
    Data_in = '0; Round_key = '0; Last_round = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 reset_checks("reset");

    dir_test("fips_r1", 128'hd42711aee0bf98f1b8b45de51e415230,
             128'ha0fafe1788542cb123a339392a6c7605, 1'b0,
             128'ha49c7ff2689f352b6b5bea43026a5049);
    dir_test("final_sr", 128'h000102030405060708090a0b0c0d0e0f, '0, 1'b1,
             128'h00050a0f04090e03080d02070c01060b);
    dir_test("mix_only", 128'hd42711aee0bf98f1b8b45de51e415230, '0, 1'b0,
             128'h046681e5e0cb199a48f8d37a2806264c);
    @(negedge clk);

    run_stream(1, 16);
    run_stream(2, 5);
    run_stream(0, 200);

    // Two beats in flight, then reset.
    @(negedge clk);
    In_valid = 1'b1; Out_ready = 1'b0; rand_inputs();
    @(negedge clk);
    rand_inputs();
    @(negedge clk);
    In_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; Out_ready = 1'b1;
    #1 reset_checks("mid_reset");
    repeat (6) begin
      @(negedge clk);
      #1 chk("no_stale", Out_valid, 0);
    end

    run_stream(0, 50);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
